mio_responder: RTL and testbench
================================

Name: mio_responder

Overview:
- Memory/IO responder on the multi-cycle CPU's memory port; the target end of the CPU's address/data/ready protocol.
- Accepts one word request at a time and services it after a programmable number of wait states.
- Returns read data on data2CPU and pulses MIO_ready for one cycle on completion.
- Contains a word RAM and two memory-mapped peripherals: an LED register and a free-running cycle counter.

Parameters:
- ADDR_W, 10: RAM word-address width; RAM depth = 2**ADDR_W words.
- WAIT_CYC, 2: wait states inserted between request acceptance and the access; legal range 0..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  input  1  CPU request strobe; sampled only in IDLE.
- mem_w  input  1  1 = write, 0 = read; latched with mem_req.
- M_addr  input  32  CPU byte address; latched with mem_req.
- data_out  input  32  CPU write data; latched with mem_req.
- data2CPU  output  32  read data; valid from the MIO_ready cycle and held until the next completed read.
- MIO_ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state is not IDLE.
- led_out  output  32  LED register contents.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, MIO_ready=0, busy=0, data2CPU=0, led_out=0, cycle counter=0, wait counter=0. RAM contents are not cleared.
- States:
  - IDLE: if mem_req=1 at edge E0, latch mem_w, M_addr and data_out; load wait counter with WAIT_CYC; go to WAIT if WAIT_CYC>0, else ACCESS.
  - WAIT: decrement the counter each cycle; when it reaches 0, go to ACCESS.
  - ACCESS: perform the access at this edge; go to DONE.
  - DONE: MIO_ready=1 for this cycle only; go to IDLE unconditionally.
- Latency: MIO_ready is high during the cycle following edge E0+WAIT_CYC+1.
- Writes take effect at the ACCESS edge. Read data is registered into data2CPU at the same edge.
- Requests arriving outside IDLE are ignored, not queued. A mem_req held high is re-accepted at the first IDLE edge after DONE, i.e. back-to-back spacing is WAIT_CYC+3 cycles.
- Decode:
  - M_addr[31:28] != 4'hF: RAM, index = M_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
  - 32'hF000_0000: LED register, read/write.
  - 32'hF000_0004: cycle counter, read-only; writes are dropped.
  - Other 4'hF addresses: read 0, writes dropped.
- M_addr[1:0] is ignored; all accesses are full words.
- Cycle counter increments every clk from reset and wraps 32'hFFFF_FFFF -> 0. A read returns its value at the ACCESS edge.
- A write to the LED register completes with data2CPU unchanged. data2CPU changes only on reads.
- Reset mid-operation aborts the transaction: no MIO_ready, any pending write is discarded, state returns to IDLE.

Optional Feature:
- Macro MIO_BUS_ERR_EN.
- Defined: adds output bus_err (1 bit, reset 0). It pulses together with MIO_ready when the latched M_addr[1:0] != 0 or the address is unmapped 4'hF space. The write is suppressed and data2CPU is forced to 32'h0 for reads.
- Not defined: no bus_err port; behaviour as described above (low bits ignored, unmapped space reads 0).

Decomposition:
- Package mio_pkg holds:
  - the state encoding (IDLE, WAIT, ACCESS, DONE), 2 bits;
  - constants PERIPH_NIB=4'hF, LED_ADDR=32'hF000_0000, CNT_ADDR=32'hF000_0004.
- Sub-module mio_ram: synchronous single-port word RAM (clk, we, addr[ADDR_W-1:0], din, dout), read data registered, parameterised by ADDR_W.
- The FSM, decode, LED register and counter stay in the top level.

Test Plan:
- Write then read, WAIT_CYC=2:
  - write 32'hDEADBEEF to 32'h0000_0010; MIO_ready pulses at the 4th cycle after the accept edge;
  - read 32'h0000_0010 -> data2CPU=32'hDEADBEEF on its MIO_ready pulse.
- Wrap, ADDR_W=10: write 32'h1234_5678 to 32'h0000_1010; a read of 32'h0000_0010 returns 32'h1234_5678.
- Peripherals:
  - write 32'h0000_00A5 to F000_0000 -> led_out=32'h0000_00A5, data2CPU unchanged;
  - write to F000_0004 -> counter unaffected;
  - read F000_0004 twice, 5 requests' spacing apart -> difference equals the exact edge count;
  - read F000_0008 -> 0.
- Held mem_req=1 with WAIT_CYC=0: MIO_ready pulses every 3 cycles; toggling mem_req during WAIT/DONE produces no extra pulse.
- Reset asserted in WAIT during a write of 32'hCAFE_0000 to 32'h0000_0020: no MIO_ready, outputs go to reset values, and a subsequent read of 32'h0000_0020 returns the prior contents.
- With MIO_BUS_ERR_EN: write to 32'h0000_0022 -> bus_err=1 with MIO_ready and RAM unchanged; read F000_000C -> bus_err=1, data2CPU=0.

Source files
------------

// File: rtl/mio_pkg.sv
// mio_pkg: shared definitions for the MIO responder.
//   state_e    - responder FSM encoding (IDLE, WAIT, ACCESS, DONE), 2 bits
//   PERIPH_NIB - top address nibble selecting peripheral space
//   LED_ADDR   - LED register byte address
//   CNT_ADDR   - free-running cycle counter byte address
//   word_hit() - compares a latched word address against a byte address
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic [3:0]  PERIPH_NIB = 4'hF;
   localparam logic [31:0] LED_ADDR   = 32'hF000_0000;
   localparam logic [31:0] CNT_ADDR   = 32'hF000_0004;

   function automatic logic word_hit(input logic [29:0] waddr, input logic [31:0] byte_addr);
      return waddr == byte_addr[31:2];
   endfunction

endpackage

// File: rtl/mio_ram.sv
// mio_ram: synchronous single-port word RAM, read-first, registered read.
//   clk  - rising-edge clock
//   we   - write enable
//   addr - word index [ADDR_W-1:0]
//   din  - write data
//   dout - read data, registered (contents at addr as of the last edge)
module mio_ram #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       din,
   output logic [31:0]       dout
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      dout_q <= mem_q[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/mio_responder.sv
// mio_responder: target end of the CPU address/data/ready memory protocol.
// Accepts one word request in IDLE, inserts WAIT_CYC wait states, performs
// the access, then pulses MIO_ready for one cycle.
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   mem_req   - request strobe, sampled only in IDLE
//   mem_w     - 1 = write, 0 = read (latched with mem_req)
//   M_addr    - byte address (latched with mem_req)
//   data_out  - write data (latched with mem_req)
//   data2CPU  - read data, held until the next completed read
//   MIO_ready - one-cycle completion pulse
//   busy      - high whenever not IDLE
//   led_out   - LED register contents
//   bus_err   - (MIO_BUS_ERR_EN only) error pulse alongside MIO_ready for
//               misaligned or unmapped peripheral accesses
// Optional feature macro: MIO_BUS_ERR_EN
module mio_responder
   import mio_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_w,
   input  logic [31:0] M_addr,
   input  logic [31:0] data_out,
   output logic [31:0] data2CPU,
   output logic        MIO_ready,
   output logic        busy,
`ifdef MIO_BUS_ERR_EN
   output logic        bus_err,
`endif
   output logic [31:0] led_out
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        w_q;
   logic [29:0] waddr_q;
   logic [31:0] wdata_q;
   logic [31:0] led_q;
   logic [31:0] cnt_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        is_periph, is_led, is_cnt;
   logic        acc_err;
   logic [31:0] rd_val;
   logic [ADDR_W-1:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_dout;

   assign accept    = (state_q == IDLE) && mem_req;
   assign is_periph = (waddr_q[29:26] == PERIPH_NIB);
   assign is_led    = word_hit(waddr_q, LED_ADDR);
   assign is_cnt    = word_hit(waddr_q, CNT_ADDR);

`ifdef MIO_BUS_ERR_EN
   logic [1:0] lo_q;
   logic       bus_err_q;
   assign acc_err = (lo_q != 2'b00) || (is_periph && !is_led && !is_cnt);
   assign bus_err = bus_err_q;
`else
   logic unused_lo;
   assign unused_lo = ^M_addr[1:0];
   assign acc_err   = 1'b0;
`endif

   // The RAM read is registered, so its address follows M_addr while IDLE and
   // the latched address afterwards; ram_dout is therefore already valid for
   // the requested word during ACCESS, even with no wait states.
   assign ram_addr = (state_q == IDLE) ? M_addr[ADDR_W+1:2] : waddr_q[ADDR_W-1:0];
   assign ram_we   = (state_q == ACCESS) && w_q && !is_periph && !acc_err;

   mio_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (wdata_q),
      .dout (ram_dout)
   );

   always_comb begin
      rd_val = '0;
      if (acc_err) begin
         rd_val = '0;
      end else if (!is_periph) begin
         rd_val = ram_dout;
      end else if (is_led) begin
         rd_val = led_q;
      end else if (is_cnt) begin
         rd_val = cnt_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               wcnt_d  = WAIT_INIT;
               state_d = (WAIT_CYC > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) begin
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      MIO_ready = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   // Datapath: request latch, peripherals, read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q     <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         led_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
`ifdef MIO_BUS_ERR_EN
         lo_q      <= '0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_q + 32'd1;
         if (accept) begin
            w_q     <= mem_w;
            waddr_q <= M_addr[31:2];
            wdata_q <= data_out;
`ifdef MIO_BUS_ERR_EN
            lo_q    <= M_addr[1:0];
`endif
         end
`ifdef MIO_BUS_ERR_EN
         bus_err_q <= (state_q == ACCESS) && acc_err;
`endif
         if (state_q == ACCESS) begin
            if (!w_q) begin
               rdata_q <= rd_val;
            end else if (is_led && !acc_err) begin
               led_q <= wdata_q;
            end
         end
      end
   end

   assign data2CPU = rdata_q;
   assign led_out  = led_q;

endmodule

// File: tb/tb_mio_responder.sv
module tb_mio_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // main DUT, WAIT_CYC = 2
   logic        mem_req = 1'b0, mem_w = 1'b0;
   logic [31:0] M_addr = '0, data_out = '0;
   logic [31:0] data2CPU, led_out;
   logic        MIO_ready, busy;
   logic        bus_err;

   // zero-wait DUT for back-to-back spacing
   logic        req0 = 1'b0;
   logic [31:0] rd0, led0;
   logic        rdy0, busy0;
   logic        be0;

   mio_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_w     (mem_w),
      .M_addr    (M_addr),
      .data_out  (data_out),
      .data2CPU  (data2CPU),
      .MIO_ready (MIO_ready),
      .busy      (busy),
`ifdef MIO_BUS_ERR_EN
      .bus_err   (bus_err),
`endif
      .led_out   (led_out)
   );

   mio_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (req0),
      .mem_w     (1'b0),
      .M_addr    (32'hF000_0000),
      .data_out  (32'h0),
      .data2CPU  (rd0),
      .MIO_ready (rdy0),
      .busy      (busy0),
`ifdef MIO_BUS_ERR_EN
      .bus_err   (be0),
`endif
      .led_out   (led0)
   );

`ifndef MIO_BUS_ERR_EN
   assign bus_err = 1'b0;
   assign be0     = 1'b0;
`endif

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int tests_run = 0;
   int fails = 0;

   // One request on the main DUT; lat counts falling edges from the accept
   // edge to the one where MIO_ready is seen (-1 on timeout).
   task automatic drv(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic be, output int acc);
      @(negedge clk);
      mem_req = 1'b1; mem_w = w; M_addr = a; data_out = d;
      @(posedge clk); #1;
      acc = edge_cnt;
      mem_req = 1'b0;
      lat = -1; rd = '0; be = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (MIO_ready) begin
            lat = i; rd = data2CPU; be = bus_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (MIO_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", MIO_ready); end
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (data2CPU !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", data2CPU); end
      tests_run++; if (led_out !== 32'h0) begin fails++; $display("FAIL reset_led: got %h want 0", led_out); end
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      int lat, acc; logic [31:0] rd; logic be;
      drv(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, be, acc);
      tests_run++; if (lat !== 4) begin fails++; $display("FAIL wr_latency: got %0d want 4", lat); end
      tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL wr_data_unchanged: got %h want 0", rd); end
      tests_run++; if (be !== 1'b0) begin fails++; $display("FAIL wr_buserr: got %b want 0", be); end
      drv(1'b0, 32'h0000_0010, 32'h0, lat, rd, be, acc);
      tests_run++; if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d want 4", lat); end
      tests_run++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_wrap();
      int lat, acc; logic [31:0] rd; logic be;
      drv(1'b1, 32'h0000_1010, 32'h1234_5678, lat, rd, be, acc);
      drv(1'b0, 32'h0000_0010, 32'h0, lat, rd, be, acc);
      tests_run++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL wrap_data: got %h want 12345678", rd); end
   endtask

   task automatic test_periph();
      int lat, acc1, acc2, acc; logic [31:0] rd, c1, c2; logic be;
      drv(1'b1, 32'hF000_0000, 32'h0000_00A5, lat, rd, be, acc);
      tests_run++; if (led_out !== 32'h0000_00A5) begin fails++; $display("FAIL led_write: got %h want a5", led_out); end
      tests_run++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL led_data_unchanged: got %h want 12345678", rd); end
      drv(1'b0, 32'hF000_0000, 32'h0, lat, rd, be, acc);
      tests_run++; if (rd !== 32'h0000_00A5) begin fails++; $display("FAIL led_read: got %h want a5", rd); end
      drv(1'b0, 32'hF000_0004, 32'h0, lat, c1, be, acc1);
      drv(1'b1, 32'hF000_0004, 32'h0000_0000, lat, rd, be, acc);
      drv(1'b0, 32'h0000_0010, 32'h0, lat, rd, be, acc);
      drv(1'b1, 32'hF000_0004, 32'hFFFF_0000, lat, rd, be, acc);
      drv(1'b0, 32'hF000_0004, 32'h0, lat, c2, be, acc2);
      tests_run++;
      if (c2 - c1 !== 32'(acc2 - acc1)) begin
         fails++; $display("FAIL cnt_delta: got %0d want %0d", c2 - c1, acc2 - acc1);
      end
      drv(1'b0, 32'hF000_0008, 32'h0, lat, rd, be, acc);
      tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h want 0", rd); end
   endtask

   task automatic test_wait_toggle();
      logic [12:0] mask = '0;
      @(negedge clk);
      mem_req = 1'b1; mem_w = 1'b0; M_addr = 32'hF000_0000;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (MIO_ready) mask[i] = 1'b1;
         case (i)
            1: mem_req = 1'b0;
            2: mem_req = 1'b1;
            3: mem_req = 1'b0;
            4: mem_req = 1'b1;
            default: mem_req = 1'b0;
         endcase
      end
      tests_run++; if (mask !== 13'h0010) begin fails++; $display("FAIL wait_toggle_pulses: got %h want 0010", mask); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] mask = '0;
      @(negedge clk);
      req0 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (rdy0) mask[i] = 1'b1;
      end
      req0 = 1'b0;
      tests_run++; if (mask !== 13'h0924) begin fails++; $display("FAIL b2b_pulses: got %h want 0924", mask); end
      repeat (2) @(negedge clk);
      mask = '0;
      req0 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (rdy0) mask[i] = 1'b1;
         req0 = (i == 2);
      end
      req0 = 1'b0;
      tests_run++; if (mask !== 13'h0004) begin fails++; $display("FAIL b2b_toggle_pulses: got %h want 0004", mask); end
   endtask

   task automatic test_reset_mid();
      int lat, acc, pulses; logic [31:0] rd; logic be;
      drv(1'b1, 32'h0000_0020, 32'h0BAD_F00D, lat, rd, be, acc);
      @(negedge clk);
      mem_req = 1'b1; mem_w = 1'b1; M_addr = 32'h0000_0020; data_out = 32'hCAFE_0000;
      @(posedge clk); #1;
      mem_req = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
      tests_run++; if (data2CPU !== 32'h0) begin fails++; $display("FAIL midrst_data: got %h want 0", data2CPU); end
      tests_run++; if (led_out !== 32'h0) begin fails++; $display("FAIL midrst_led: got %h want 0", led_out); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (MIO_ready) pulses++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (MIO_ready) pulses++;
      end
      tests_run++; if (pulses !== 0) begin fails++; $display("FAIL midrst_ready: got %0d pulses want 0", pulses); end
      drv(1'b0, 32'h0000_0020, 32'h0, lat, rd, be, acc);
      tests_run++; if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL midrst_ram: got %h want 0badf00d", rd); end
   endtask

`ifdef MIO_BUS_ERR_EN
   task automatic test_bus_err();
      int lat, acc; logic [31:0] rd; logic be;
      drv(1'b1, 32'h0000_0022, 32'h5555_5555, lat, rd, be, acc);
      tests_run++; if (be !== 1'b1) begin fails++; $display("FAIL berr_misaligned: got %b want 1", be); end
      tests_run++; if (lat !== 4) begin fails++; $display("FAIL berr_latency: got %0d want 4", lat); end
      drv(1'b0, 32'h0000_0020, 32'h0, lat, rd, be, acc);
      tests_run++; if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL berr_ram_kept: got %h want 0badf00d", rd); end
      tests_run++; if (be !== 1'b0) begin fails++; $display("FAIL berr_clean: got %b want 0", be); end
      drv(1'b0, 32'hF000_000C, 32'h0, lat, rd, be, acc);
      tests_run++; if (be !== 1'b1) begin fails++; $display("FAIL berr_unmapped: got %b want 1", be); end
      tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL berr_data: got %h want 0", rd); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_periph();
      test_wait_toggle();
      test_back_to_back();
      test_reset_mid();
`ifdef MIO_BUS_ERR_EN
      test_bus_err();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
